// File: rtl/tick_serial_tx.sv
// Tick-paced serial transmitter: takes a word over valid/ready and sends it framed
// as start, data LSB-first, optional even parity, then STOP_BITS stop bits.
// Each line bit lasts one period of the external 'tick' strobe.
// Optional feature macro: TICK_SERIAL_TX_PARITY_EN (adds the PARITY state).
module tick_serial_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              txd,
  output logic              busy,
  output logic [2:0]        state
);

  // Wide enough for DATA_W-1 (max 15) and STOP_BITS-1.
  localparam int unsigned CntW = 4;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWait   = 3'd1,
    StStart  = 3'd2,
    StData   = 3'd3,
    StParity = 3'd4,
    StStop   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] shift_nxt;
`ifdef TICK_SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign shift_nxt = shift_q >> 1;
  assign state     = state_q;
  assign txd       = txd_q;
  assign busy      = busy_q;
  // Held low while reset is asserted even though the state already reads IDLE.
  assign din_ready = reset && (state_q == StIdle);

  // Next-state, next-line-level and datapath updates; every transition past IDLE waits on tick.
  always_comb begin
    state_d  = state_q;
    txd_d    = txd_q;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
`ifdef TICK_SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      StIdle: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (din_valid && din_ready) begin
          shift_d  = din;
`ifdef TICK_SERIAL_TX_PARITY_EN
          parity_d = ^din;
`endif
          busy_d   = 1'b1;
          state_d  = StWait;
        end
      end
      // Holding here until a tick aligns the start bit to a full tick period.
      StWait: begin
        if (tick) begin
          state_d = StStart;
          txd_d   = 1'b0;
        end
      end
      StStart: begin
        if (tick) begin
          state_d = StData;
          txd_d   = shift_q[0];
          cnt_d   = '0;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = shift_nxt;
          if (cnt_q == CntW'(DATA_W - 1)) begin
            cnt_d   = '0;
`ifdef TICK_SERIAL_TX_PARITY_EN
            state_d = StParity;
            txd_d   = parity_q;
`else
            state_d = StStop;
            txd_d   = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + CntW'(1);
            txd_d = shift_nxt[0];
          end
        end
      end
`ifdef TICK_SERIAL_TX_PARITY_EN
      StParity: begin
        if (tick) begin
          state_d = StStop;
          txd_d   = 1'b1;
          cnt_d   = '0;
        end
      end
`endif
      StStop: begin
        if (tick) begin
          if (cnt_q == CntW'(STOP_BITS - 1)) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            txd_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      // Unused encodings fall back to a clean idle line.
      default: begin
        state_d = StIdle;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs; synchronous active-low reset abandons any frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      shift_q  <= '0;
`ifdef TICK_SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
`ifdef TICK_SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_tick_serial_tx.sv
// Bench for tick_serial_tx: tick every 3 clk, frames predicted from the bit-list definition
// of a frame and checked cycle by cycle, plus directed, back-to-back and mid-frame reset cases.
module tb_tick_serial_tx;

  localparam int unsigned DW = 8;
  localparam int unsigned SB = 1;
`ifdef TICK_SERIAL_TX_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif

  logic          clk;
  logic          reset;
  logic          tick;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic          txd;
  logic          busy;
  logic [2:0]    state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  tick_serial_tx #(
    .DATA_W   (DW),
    .STOP_BITS(SB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .txd      (txd),
    .busy     (busy),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock edge; tick is high for every edge whose index is a multiple of 3.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    tick = ((cyc + 1) % 3 == 0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      din       = DW'($urandom);
      din_valid = 1'b0;
      step();
      check_eq("idle_txd", 32'(txd), 32'd1);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_state", 32'(state), 32'd0);
      check_eq("idle_ready", 32'(din_ready), 32'd1);
    end
  endtask

  // Send one word; abort_off >= 0 asserts reset at that edge offset from the start bit.
  task automatic send_frame(input logic [DW-1:0] data, input int abort_off);
    int bits[$];
    int acc, s, endn, j, st;
    check_eq("pre_ready", 32'(din_ready), 32'd1);
    check_eq("pre_busy", 32'(busy), 32'd0);
    check_eq("pre_txd", 32'(txd), 32'd1);
    bits.push_back(0);
    for (int i = 0; i < int'(DW); i++) bits.push_back(int'(data[i]));
    if (P == 1) bits.push_back(int'(^data));
    for (int i = 0; i < int'(SB); i++) bits.push_back(1);
    din       = data;
    din_valid = 1'b1;
    step();
    acc = cyc;
    s = acc + 1;
    while (s % 3 != 0) s++;
    endn = s + 3 * bits.size();
    for (int n = acc; n <= endn; n++) begin
      if (n != acc) begin
        if (abort_off >= 0 && n == s + abort_off) begin
          reset     = 1'b0;
          din_valid = 1'b0;
          step();
          check_eq("abort_txd", 32'(txd), 32'd1);
          check_eq("abort_state", 32'(state), 32'd0);
          check_eq("abort_busy", 32'(busy), 32'd0);
          check_eq("abort_ready_in_reset", 32'(din_ready), 32'd0);
          reset = 1'b1;
          #1;
          check_eq("abort_ready_after", 32'(din_ready), 32'd1);
          return;
        end
        // Line must ignore din and din_valid while the frame is in flight.
        din       = DW'($urandom);
        din_valid = 1'($urandom_range(0, 1));
        step();
      end
      if (n < s) begin
        check_eq("wait_txd", 32'(txd), 32'd1);
        check_eq("wait_busy", 32'(busy), 32'd1);
        check_eq("wait_state", 32'(state), 32'd1);
        check_eq("wait_ready", 32'(din_ready), 32'd0);
      end else if (n < endn) begin
        j = (n - s) / 3;
        if (j == 0) st = 2;
        else if (j <= int'(DW)) st = 3;
        else if (P == 1 && j == int'(DW) + 1) st = 4;
        else st = 5;
        check_eq("frame_txd", 32'(txd), 32'(bits[j]));
        check_eq("frame_busy", 32'(busy), 32'd1);
        check_eq("frame_state", 32'(state), 32'(st));
        check_eq("frame_ready", 32'(din_ready), 32'd0);
      end else begin
        check_eq("end_txd", 32'(txd), 32'd1);
        check_eq("end_busy", 32'(busy), 32'd0);
        check_eq("end_state", 32'(state), 32'd0);
        check_eq("end_ready", 32'(din_ready), 32'd1);
      end
    end
    din_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    tick      = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    step();
    step();
    check_eq("rst_txd", 32'(txd), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_ready_low", 32'(din_ready), 32'd0);
    reset = 1'b1;
    #1;
    check_eq("rst_ready_high", 32'(din_ready), 32'd1);

    idle(2);
    send_frame(8'hA5, -1);
    idle(2);
    send_frame(8'h01, -1);
    idle(1);
    send_frame(8'hFF, -1);
    // Back-to-back: second word accepted on the cycle after the first returns to IDLE.
    send_frame(8'h3C, -1);
    send_frame(8'hC3, -1);
    idle(3);
    // Reset during data bit 4 of 8'h00, then a clean full frame.
    send_frame(8'h00, 16);
    idle(1);
    send_frame(8'h5A, -1);

    for (int i = 0; i < 24; i++) begin
      idle($urandom_range(0, 4));
      send_frame(DW'($urandom), -1);
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
